conv_bram_sr_img_loader: RTL and testbench

CONV_BRAM_SR_IMG_LOADER -- requirements
Module: conv_bram_sr_img_loader

---
 rtl/conv_bram_sr_img_loader_pkg.sv | 20 ++
 rtl/conv_bram_sr_img_loader_if.sv | 30 +++
 rtl/conv_bram_sr_img_loader_counter.sv | 32 +++
 rtl/conv_bram_sr_img_loader.sv | 111 +++++++++++
 tb/tb_conv_bram_sr_img_loader.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/conv_bram_sr_img_loader_pkg.sv
// Shared types and size helpers for the striped image loader.
// Shared by the loader, its bus interface and the counter.
package conv_bram_sr_img_loader_pkg;

  typedef enum logic [1:0] {LOAD, HANDOFF, BUSY} state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Rows held by one bank; the last stripe may be partially filled.
  function automatic int stripe_rows(input int img_h, input int filter_l);
    return (img_h + filter_l - 1) / filter_l;
  endfunction

  function automatic int addr_w(input int img_w, input int img_h, input int filter_l);
    return cnt_w(stripe_rows(img_h, filter_l) * img_w);
  endfunction

endpackage

// File: rtl/conv_bram_sr_img_loader_if.sv
// Pixel stream, bank write port and convolution handshake of the image loader.
interface conv_bram_sr_img_loader_if
  import conv_bram_sr_img_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int IMG_D      = 4,
  parameter int FILTER_L   = 3,
  parameter int ADDR_W     = addr_w(16, 16, 3)
);
  logic                        pix_val;
  logic                        pix_rdy;
  logic [DATA_WIDTH*IMG_D-1:0] pix_data;
  logic [FILTER_L-1:0]         img_wren;
  logic [ADDR_W-1:0]           img_wraddr;
  logic [DATA_WIDTH*IMG_D-1:0] img_wrdata;
  logic                        conv_val;
  logic                        conv_rdy;
  logic                        conv_last;

  modport master (
    input  pix_val, pix_data, conv_rdy, conv_last,
    output pix_rdy, img_wren, img_wraddr, img_wrdata, conv_val
  );

  modport slave (
    output pix_val, pix_data, conv_rdy, conv_last,
    input  pix_rdy, img_wren, img_wraddr, img_wrdata, conv_val
  );

endinterface

// File: rtl/conv_bram_sr_img_loader_counter.sv
// Modulo counter built on an adder: advances by STEP when enabled, wraps at MODULUS.
module vc_counter_adder
  import conv_bram_sr_img_loader_pkg::*;
#(
  parameter int MODULUS = 3,
  parameter int STEP    = 1,
  parameter int CNT_W   = cnt_w(MODULUS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             at_wrap
);

  logic [CNT_W:0] sum;
  logic [CNT_W:0] nxt;

  // at_wrap flags that the next enabled step rolls over.
  always_comb begin
    sum     = {1'b0, cnt} + (CNT_W+1)'(STEP);
    at_wrap = (sum >= (CNT_W+1)'(MODULUS));
    nxt     = at_wrap ? sum - (CNT_W+1)'(MODULUS) : sum;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en)      cnt <= nxt[CNT_W-1:0];
  end

endmodule

// File: rtl/conv_bram_sr_img_loader.sv
// Loads a raster pixel stream into FILTER_L row-striped banks, then hands off to the convolution.
module conv_bram_sr_img_loader
  import conv_bram_sr_img_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int IMG_W      = 16,
  parameter int IMG_H      = 16,
  parameter int IMG_D      = 4,
  parameter int FILTER_L   = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  conv_bram_sr_img_loader_if.master   bus
);

  localparam int STRIPE_ROWS = stripe_rows(IMG_H, FILTER_L);
  localparam int ADDR_W      = addr_w(IMG_W, IMG_H, FILTER_L);
  localparam int W_W         = cnt_w(IMG_W);
  localparam int H_W         = cnt_w(IMG_H);
  localparam int S_W         = cnt_w(FILTER_L);
  localparam int R_W         = cnt_w(STRIPE_ROWS);

  state_t state, state_nx;

  logic           accept_p0;
  logic           row_end_p0;
  logic           img_end_p0;
  logic [W_W-1:0] w;
  logic [H_W-1:0] h;
  logic [S_W-1:0] sidx;
  logic [R_W-1:0] srow;
  logic           sidx_wrap;
  logic           h_wrap_unused;
  logic           srow_wrap_unused;

  logic [FILTER_L-1:0] bank_p0;
  logic [ADDR_W-1:0]   addr_p0;

  assign accept_p0  = bus.pix_val && bus.pix_rdy;
  assign row_end_p0 = accept_p0 && (w == W_W'(IMG_W - 1));
  assign img_end_p0 = row_end_p0 && (h == H_W'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (reset || img_end_p0) w <= '0;
    else if (row_end_p0)     w <= '0;
    else if (accept_p0)      w <= w + W_W'(1);
  end

  vc_counter_adder #(.MODULUS(IMG_H), .STEP(1), .CNT_W(H_W)) u_h_cnt (
    .clk(clk), .reset(reset), .clr(img_end_p0), .en(row_end_p0),
    .cnt(h), .at_wrap(h_wrap_unused)
  );

  // h mod FILTER_L selects the bank; its wrap advances the row inside the stripe.
  vc_counter_adder #(.MODULUS(FILTER_L), .STEP(1), .CNT_W(S_W)) u_sidx_cnt (
    .clk(clk), .reset(reset), .clr(img_end_p0), .en(row_end_p0),
    .cnt(sidx), .at_wrap(sidx_wrap)
  );

  vc_counter_adder #(.MODULUS(STRIPE_ROWS), .STEP(1), .CNT_W(R_W)) u_srow_cnt (
    .clk(clk), .reset(reset), .clr(img_end_p0), .en(row_end_p0 && sidx_wrap),
    .cnt(srow), .at_wrap(srow_wrap_unused)
  );

  always_comb begin
    bank_p0 = FILTER_L'(1) << sidx;
    addr_p0 = ADDR_W'(srow) * ADDR_W'(IMG_W) + ADDR_W'(w);
  end

  // p0 -> p1: write port registered one cycle after the accepting edge
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.img_wren   <= '0;
      bus.img_wraddr <= '0;
      bus.img_wrdata <= '0;
    end else begin
      bus.img_wren <= accept_p0 ? bank_p0 : '0;
      if (accept_p0) begin
        bus.img_wraddr <= addr_p0;
        bus.img_wrdata <= bus.pix_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nx;
  end

  // Entering HANDOFF on the same edge as the last write lines conv_val up with it.
  always_comb begin
    state_nx     = state;
    bus.pix_rdy  = 1'b0;
    bus.conv_val = 1'b0;
    case (state)
      LOAD: begin
        bus.pix_rdy = 1'b1;
        if (img_end_p0) state_nx = HANDOFF;
      end
      HANDOFF: begin
        bus.conv_val = 1'b1;
        if (bus.conv_rdy) state_nx = BUSY;
      end
      BUSY: begin
        if (bus.conv_last) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

endmodule

// File: tb/tb_conv_bram_sr_img_loader.sv
// Directed bench for the striped image loader on a 4x5 image with 3 banks.
module tb_conv_bram_sr_img_loader;
  import conv_bram_sr_img_loader_pkg::*;

  localparam int DW = 12;
  localparam int IW = 4;
  localparam int IH = 5;
  localparam int ID = 4;
  localparam int FL = 3;
  localparam int AW = addr_w(IW, IH, FL);
  localparam int PW = DW * ID;

  logic clk = 1'b0;
  logic reset;

  conv_bram_sr_img_loader_if #(.DATA_WIDTH(DW), .IMG_D(ID), .FILTER_L(FL), .ADDR_W(AW)) bus ();

  conv_bram_sr_img_loader #(
    .DATA_WIDTH(DW), .IMG_W(IW), .IMG_H(IH), .IMG_D(ID), .FILTER_L(FL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;
  int seen [FL][8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pix(input int p);
    logic [PW-1:0] d;
    d = '0;
    for (int c = 0; c < ID; c++) d[c*DW +: DW] = DW'(p * 16 + c + 1);
    return d;
  endfunction

  function automatic logic [FL-1:0] exp_bank(input int p);
    logic [FL-1:0] one;
    one = 1;
    return one << ((p / IW) % FL);
  endfunction

  function automatic int exp_addr(input int p);
    return ((p / IW) / FL) * IW + (p % IW);
  endfunction

  task automatic beat(input int p);
    bus.pix_val  = 1'b1;
    bus.pix_data = pix(p);
    step();
    bus.pix_val = 1'b0;
    chk($sformatf("wren p%0d", p), 64'(bus.img_wren), 64'(exp_bank(p)));
    chk($sformatf("addr p%0d", p), 64'(bus.img_wraddr), 64'(exp_addr(p)));
    chk($sformatf("data p%0d", p), 64'(bus.img_wrdata), 64'(pix(p)));
    for (int b = 0; b < FL; b++)
      if (bus.img_wren[b]) seen[b][int'(bus.img_wraddr)]++;
  endtask

  initial begin
    reset         = 1'b1;
    bus.pix_val   = 1'b0;
    bus.pix_data  = '0;
    bus.conv_rdy  = 1'b0;
    bus.conv_last = 1'b0;
    step();
    step();
    chk("rst pix_rdy", 64'(bus.pix_rdy), 64'd1);
    chk("rst wren", 64'(bus.img_wren), 64'd0);
    chk("rst addr", 64'(bus.img_wraddr), 64'd0);
    chk("rst data", 64'(bus.img_wrdata), 64'd0);
    chk("rst conv_val", 64'(bus.conv_val), 64'd0);
    reset = 1'b0;

    // Full-rate image 0..19
    for (int p = 0; p < IW * IH; p++) begin
      chk($sformatf("rdy p%0d", p), 64'(bus.pix_rdy), 64'd1);
      beat(p);
      if (p == 14) begin
        chk("p14 wren", 64'(bus.img_wren), 64'b001);
        chk("p14 addr", 64'(bus.img_wraddr), 64'd6);
      end
      if (p == 18) begin
        chk("p18 wren", 64'(bus.img_wren), 64'b010);
        chk("p18 addr", 64'(bus.img_wraddr), 64'd6);
      end
      chk($sformatf("conv_val p%0d", p), 64'(bus.conv_val), (p == IW * IH - 1) ? 64'd1 : 64'd0);
    end
    chk("handoff pix_rdy", 64'(bus.pix_rdy), 64'd0);

    // HANDOFF: conv_last and pix_val ignored, conv_rdy held low
    bus.conv_last = 1'b1;
    bus.pix_val   = 1'b1;
    bus.pix_data  = pix(99);
    step();
    bus.conv_last = 1'b0;
    chk("handoff last ignored", 64'(bus.conv_val), 64'd1);
    chk("handoff no write", 64'(bus.img_wren), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold conv_val %0d", i), 64'(bus.conv_val), 64'd1);
      chk($sformatf("hold pix_rdy %0d", i), 64'(bus.pix_rdy), 64'd0);
      chk($sformatf("hold wren %0d", i), 64'(bus.img_wren), 64'd0);
    end
    bus.pix_val  = 1'b0;
    bus.conv_rdy = 1'b1;
    step();
    bus.conv_rdy = 1'b0;
    chk("busy conv_val", 64'(bus.conv_val), 64'd0);
    chk("busy pix_rdy", 64'(bus.pix_rdy), 64'd0);
    bus.conv_rdy = 1'b1;
    step();
    bus.conv_rdy = 1'b0;
    step();
    chk("busy hold pix_rdy", 64'(bus.pix_rdy), 64'd0);
    chk("busy rdy ignored", 64'(bus.conv_val), 64'd0);
    bus.conv_last = 1'b1;
    step();
    bus.conv_last = 1'b0;
    chk("reload pix_rdy", 64'(bus.pix_rdy), 64'd1);
    chk("reload conv_val", 64'(bus.conv_val), 64'd0);

    // Second image with random idle gaps, scoreboarded per bank/address
    foreach (seen[b, a]) seen[b][a] = 0;
    for (int p = 0; p < IW * IH; p++) begin
      int g;
      g = $urandom_range(0, 2);
      for (int k = 0; k < g; k++) begin
        step();
        chk($sformatf("gap wren p%0d", p), 64'(bus.img_wren), 64'd0);
      end
      beat(p);
      if (p == 0) begin
        chk("first wren", 64'(bus.img_wren), 64'b001);
        chk("first addr", 64'(bus.img_wraddr), 64'd0);
      end
    end
    chk("gap img conv_val", 64'(bus.conv_val), 64'd1);
    for (int b = 0; b < FL; b++)
      for (int a = 0; a < 8; a++)
        chk($sformatf("once b%0d a%0d", b, a), 64'(seen[b][a]), (b < 2 || a < 4) ? 64'd1 : 64'd0);

    bus.conv_rdy = 1'b1;
    step();
    bus.conv_rdy  = 1'b0;
    bus.conv_last = 1'b1;
    step();
    bus.conv_last = 1'b0;
    chk("back to load", 64'(bus.pix_rdy), 64'd1);

    // Reset after 7 beats discards the partial image
    for (int p = 0; p < 7; p++) beat(p);
    reset = 1'b1;
    step();
    chk("mid rst pix_rdy", 64'(bus.pix_rdy), 64'd1);
    chk("mid rst wren", 64'(bus.img_wren), 64'd0);
    chk("mid rst conv_val", 64'(bus.conv_val), 64'd0);
    reset = 1'b0;
    beat(0);
    chk("post rst wren", 64'(bus.img_wren), 64'b001);
    chk("post rst addr", 64'(bus.img_wraddr), 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
